// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite compositor: orientation codes,
// the packed RGB type, default colour keys and the orientation-to-ROM mapping.
package sprite_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef logic [23:0] rgb_t;

    localparam rgb_t DEF_KEY_COLOR = 24'hFF0000;
    localparam rgb_t DEF_BG_COLOR  = 24'hFFFFFF;

    // Codes 0 and 5..7 mark a sprite as hidden.
    function automatic logic dir_is_valid(input logic [2:0] dir);
        return (dir >= DIR_UP) && (dir <= DIR_DOWN);
    endfunction

    function automatic logic [1:0] dir_to_sel(input logic [2:0] dir);
        case (dir)
            DIR_RIGHT: return 2'd1;
            DIR_LEFT:  return 2'd2;
            DIR_DOWN:  return 2'd3;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// Stage 1 of the compositor for one sprite: bounds check against the current
// pixel and registered ROM address / orientation select.
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int SPR_W  = 32,
    parameter int SPR_H  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              pix_valid,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              en,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    input  logic [2:0]        spr_dir,
    output logic              hit,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [1:0]        rom_sel
);

    localparam int XB = $clog2(SPR_W);
    localparam int YB = $clog2(SPR_H);

    // One extra bit keeps sprites near the right/bottom edge from wrapping.
    logic [10:0]       dx, dy;
    logic              in_x, in_y;
    logic              hit_d, hit_q;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic [1:0]        rom_sel_d, rom_sel_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        dx         = {1'b0, draw_x} - {1'b0, spr_x};
        dy         = {1'b0, draw_y} - {1'b0, spr_y};
        in_x       = (draw_x >= spr_x) && (dx < 11'(SPR_W));
        in_y       = (draw_y >= spr_y) && (dy < 11'(SPR_H));
        hit_d      = en && dir_is_valid(spr_dir) && pix_valid && in_x && in_y;
        rom_sel_d  = dir_to_sel(spr_dir);
        rom_addr_d = '0;
        if (hit_d) begin
            rom_addr_d = ADDR_W'({dy[YB-1:0], dx[XB-1:0]});
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_q      <= 1'b0;
            rom_addr_q <= '0;
            rom_sel_q  <= 2'd0;
        end else begin
            hit_q      <= hit_d;
            rom_addr_q <= rom_addr_d;
            rom_sel_q  <= rom_sel_d;
        end
    end

    assign hit      = hit_q;
    assign rom_addr = rom_addr_q;
    assign rom_sel  = rom_sel_q;

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage priority compositor of NUM_SPRITES sprites over a flat background.
// Optional sticky overlap detection is enabled by defining SPRITE_COLLISION_EN.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int   NUM_SPRITES = 4,
    parameter int   SPR_W       = 32,
    parameter int   SPR_H       = 32,
    parameter int   ADDR_W      = 10,
    parameter rgb_t KEY_COLOR   = DEF_KEY_COLOR,
    parameter rgb_t BG_COLOR    = DEF_BG_COLOR
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          pix_valid,
    input  logic                          frame_start,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [NUM_SPRITES-1:0]        spr_en,
    input  logic [NUM_SPRITES*10-1:0]     spr_x,
    input  logic [NUM_SPRITES*10-1:0]     spr_y,
    input  logic [NUM_SPRITES*3-1:0]      spr_dir,
    output logic [NUM_SPRITES*ADDR_W-1:0] rom_addr,
    output logic [NUM_SPRITES*2-1:0]      rom_sel,
    input  logic [NUM_SPRITES*24-1:0]     rom_data,
    output logic [7:0]                    VGA_R,
    output logic [7:0]                    VGA_G,
    output logic [7:0]                    VGA_B,
    output logic                          vga_valid,
    output logic [NUM_SPRITES-1:0]        collision
);

    logic [NUM_SPRITES-1:0] hit1, hit2_q, opaque;
    logic                   valid1_q, valid2_q;
    logic                   vga_valid_d, vga_valid_q;
    rgb_t                   pix_d, pix_q;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        sprite_hit_unit #(
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H),
            .ADDR_W (ADDR_W)
        ) u_hit (
            .Clk       (Clk),
            .Reset_n   (Reset_n),
            .pix_valid (pix_valid),
            .draw_x    (DrawX),
            .draw_y    (DrawY),
            .en        (spr_en[i]),
            .spr_x     (spr_x[10*i +: 10]),
            .spr_y     (spr_y[10*i +: 10]),
            .spr_dir   (spr_dir[3*i +: 3]),
            .hit       (hit1[i]),
            .rom_addr  (rom_addr[ADDR_W*i +: ADDR_W]),
            .rom_sel   (rom_sel[2*i +: 2])
        );
    end

    // Stage 3: walk from lowest priority up so index 0 wins ties.
    always_comb begin
        opaque = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque[i] = hit2_q[i] && (rom_data[24*i +: 24] != KEY_COLOR);
        end
        pix_d = BG_COLOR;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pix_d = rom_data[24*i +: 24];
            end
        end
        if (!valid2_q) begin
            pix_d = '0;
        end
        vga_valid_d = valid2_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid1_q    <= 1'b0;
            valid2_q    <= 1'b0;
            hit2_q      <= '0;
            vga_valid_q <= 1'b0;
            pix_q       <= '0;
        end else begin
            valid1_q    <= pix_valid;
            valid2_q    <= valid1_q;
            hit2_q      <= hit1;
            vga_valid_q <= vga_valid_d;
            pix_q       <= pix_d;
        end
    end

    assign VGA_R     = pix_q[23:16];
    assign VGA_G     = pix_q[15:8];
    assign VGA_B     = pix_q[7:0];
    assign vga_valid = vga_valid_q;

`ifdef SPRITE_COLLISION_EN
    logic                   fs1_q, fs2_q;
    logic                   multi;
    logic [NUM_SPRITES-1:0] collision_d, collision_q;

    // Two or more opaque bits: clearing the lowest set bit leaves something.
    assign multi = (opaque & (opaque - 1'b1)) != '0;

    // Set wins over the frame clear so an overlap on the first pixel is kept.
    always_comb begin
        collision_d = fs2_q ? '0 : collision_q;
        if (multi) begin
            collision_d = collision_d | opaque;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fs1_q       <= 1'b0;
            fs2_q       <= 1'b0;
            collision_q <= '0;
        end else begin
            fs1_q       <= frame_start;
            fs2_q       <= fs1_q;
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;
`else
    logic unused_frame_start;
    assign unused_frame_start = frame_start;
    assign collision          = '0;
`endif

endmodule
